// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button path: the event-classifier state encoding,
// the default timing constants used by the debouncer/event pair, and a small
// helper that tells whether a state represents a held button.
// -----------------------------------------------------------------------------
package btn_pkg;

  // Event-classifier states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } btn_state_e;

  // Default timings in clk cycles
  localparam int unsigned BTN_LONG_COUNT   = 32'd1000;
  localparam int unsigned BTN_DBL_GAP      = 32'd300;
  localparam int unsigned BTN_REPEAT_COUNT = 32'd200;
  localparam int unsigned BTN_CNT_W        = 32'd20;

  // True for every state in which the button is considered held down
  function automatic logic btn_is_held(input btn_state_e s);
    logic held;
    case (s)
      PRESS1, PRESS2, LONG_HOLD: held = 1'b1;
      default:                   held = 1'b0;
    endcase
    return held;
  endfunction

endpackage

// File: rtl/btn_event_timer.sv
// -----------------------------------------------------------------------------
// btn_event_timer
// Up-counter with synchronous clear and enable. The count saturates at the
// terminal value term_i, and hit_o is a registered flag that is 1 while the
// count equals term_i. A single instance times the hold, gap and repeat
// periods; the owner clears it on every state change.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   clr_i   in   synchronous clear (wins over en_i)
//   en_i    in   count enable
//   term_i  in   terminal value (CNT_W bits)
//   hit_o   out  registered "count == terminal" flag
// -----------------------------------------------------------------------------
module btn_event_timer #(
  parameter int unsigned CNT_W = 32'd20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit_q;
  logic             hit_d;

  // Next count: clear first, otherwise count up and stop at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != term_i)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
    // hit is evaluated on the new count so it is valid in the next cycle
    hit_d = (cnt_d == term_i);
  end

  // Counter and hit-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/btn_event.sv
// -----------------------------------------------------------------------------
// btn_event
// Classifies a debounced, active-low button level into single-cycle event
// pulses: press, release, short click, double click, long press and
// auto-repeat. All outputs are registered; a pulse is visible in the cycle
// after the clock edge that sampled its triggering condition.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_n        in   debounced button level, 0 = pressed (synchronous to clk)
//   evt_press    out  pulse on accepted press
//   evt_release  out  pulse on release
//   evt_short    out  pulse: single short click confirmed
//   evt_double   out  pulse: double click
//   evt_long     out  pulse: hold reached LONG_COUNT
//   evt_repeat   out  pulse every REPEAT_COUNT cycles during long hold
//   pressed      out  1 while the button is considered held
//   busy         out  1 whenever the state is not IDLE
// -----------------------------------------------------------------------------
module btn_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_COUNT   = BTN_LONG_COUNT,
  parameter int unsigned DBL_GAP      = BTN_DBL_GAP,
  parameter int unsigned REPEAT_COUNT = BTN_REPEAT_COUNT,
  parameter int unsigned CNT_W        = BTN_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic evt_press,
  output logic evt_release,
  output logic evt_short,
  output logic evt_double,
  output logic evt_long,
  output logic evt_repeat,
  output logic pressed,
  output logic busy
);

  // The timer starts at 0 on entry, so the terminal is one less than the period
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_COUNT - 32'd1);
  localparam logic [CNT_W-1:0] GAP_TERM  = (DBL_GAP != 32'd0) ? CNT_W'(DBL_GAP - 32'd1) : '0;
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_COUNT - 32'd1);
  localparam logic             DBL_EN    = (DBL_GAP != 32'd0);

  btn_state_e state_q;
  btn_state_e state_d;
  logic       armed_q;
  logic       armed_d;

  logic press_q,   press_d;
  logic release_q, release_d;
  logic short_q,   short_d;
  logic double_q,  double_d;
  logic long_q,    long_d;
  logic repeat_q,  repeat_d;
  logic pressed_q, pressed_d;
  logic busy_q,    busy_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_term;
  logic             tmr_hit;

  // Next-state and event decode
  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    // A button held through reset stays ignored until it is seen released once
    armed_d   = armed_q | btn_n;

    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (armed_q && !btn_n) begin
          state_d = PRESS1;
          press_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      PRESS1: begin
        if (btn_n) begin
          release_d = 1'b1;
          tmr_clr   = 1'b1;
          if (DBL_EN) begin
            state_d = GAP;
          end else begin
            // No double-click window: the click is confirmed immediately
            short_d = 1'b1;
            state_d = IDLE;
          end
        end else if (tmr_hit) begin
          long_d  = 1'b1;
          tmr_clr = 1'b1;
          state_d = LONG_HOLD;
        end else begin
          state_d = PRESS1;
        end
      end

      GAP: begin
        // Checked before the timeout so a press on the timeout edge still wins
        if (!btn_n) begin
          press_d = 1'b1;
          tmr_clr = 1'b1;
          state_d = PRESS2;
        end else if (tmr_hit) begin
          short_d = 1'b1;
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end

      PRESS2: begin
        if (btn_n) begin
          release_d = 1'b1;
          double_d  = 1'b1;
          tmr_clr   = 1'b1;
          state_d   = IDLE;
        end else if (tmr_hit) begin
          long_d  = 1'b1;
          tmr_clr = 1'b1;
          state_d = LONG_HOLD;
        end else begin
          state_d = PRESS2;
        end
      end

      LONG_HOLD: begin
        if (btn_n) begin
          release_d = 1'b1;
          tmr_clr   = 1'b1;
          state_d   = IDLE;
        end else if (tmr_hit) begin
          // Clearing on the hit makes the timer wrap every REPEAT_COUNT cycles
          repeat_d = 1'b1;
          tmr_clr  = 1'b1;
          state_d  = LONG_HOLD;
        end else begin
          state_d = LONG_HOLD;
        end
      end

      default: begin
        tmr_clr = 1'b1;
        state_d = IDLE;
      end
    endcase

    pressed_d = btn_is_held(state_d);
    busy_d    = (state_d != IDLE);
  end

  // Terminal follows the state being entered, so hit is valid right after a clear
  always_comb begin
    tmr_term = '0;
    case (state_d)
      PRESS1, PRESS2: tmr_term = LONG_TERM;
      GAP:            tmr_term = GAP_TERM;
      LONG_HOLD:      tmr_term = REP_TERM;
      default:        tmr_term = '0;
    endcase
  end

  assign tmr_en = (state_q != IDLE);

  btn_event_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .hit_o  (tmr_hit)
  );

  // State, arming and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      pressed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      pressed_q <= pressed_d;
      busy_q    <= busy_d;
    end
  end

  assign evt_press   = press_q;
  assign evt_release = release_q;
  assign evt_short   = short_q;
  assign evt_double  = double_q;
  assign evt_long    = long_q;
  assign evt_repeat  = repeat_q;
  assign pressed     = pressed_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_btn_event.sv
// -----------------------------------------------------------------------------
// tb_btn_event
// Directed bench for btn_event with LONG_COUNT=10, DBL_GAP=6, REPEAT_COUNT=4
// (u_dut) and a second instance with DBL_GAP=0 (u_dut0). Each row drives the
// button level at a falling edge and compares the full output vector after the
// next rising edge against a hand-computed value.
// Output vector bit order: {press, release, short, double, long, repeat,
// pressed, busy}.
// -----------------------------------------------------------------------------
module tb_btn_event;

  logic clk;
  logic rst_n;
  logic btn_n;
  logic btn0_n;

  logic m_press, m_release, m_short, m_double, m_long, m_repeat, m_pressed, m_busy;
  logic z_press, z_release, z_short, z_double, z_long, z_repeat, z_pressed, z_busy;

  logic [7:0] m_vec;
  logic [7:0] z_vec;

  int n_cmp;
  int n_err;
  int row;

  // Expected output vectors
  localparam logic [7:0] V_Z   = 8'b0000_0000; // idle, no event
  localparam logic [7:0] V_P   = 8'b1000_0011; // press, held
  localparam logic [7:0] V_H   = 8'b0000_0011; // held, no event
  localparam logic [7:0] V_RG  = 8'b0100_0001; // release into gap
  localparam logic [7:0] V_G   = 8'b0000_0001; // waiting in gap
  localparam logic [7:0] V_S   = 8'b0010_0000; // short click, back to idle
  localparam logic [7:0] V_D   = 8'b0101_0000; // release + double, idle
  localparam logic [7:0] V_L   = 8'b0000_1011; // long, held
  localparam logic [7:0] V_RP  = 8'b0000_0111; // repeat, held
  localparam logic [7:0] V_RL  = 8'b0100_0000; // release from long hold
  localparam logic [7:0] V_RS  = 8'b0110_0000; // release + short together

  btn_event #(
    .LONG_COUNT   (32'd10),
    .DBL_GAP      (32'd6),
    .REPEAT_COUNT (32'd4),
    .CNT_W        (32'd20)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_n),
    .evt_press   (m_press),
    .evt_release (m_release),
    .evt_short   (m_short),
    .evt_double  (m_double),
    .evt_long    (m_long),
    .evt_repeat  (m_repeat),
    .pressed     (m_pressed),
    .busy        (m_busy)
  );

  btn_event #(
    .LONG_COUNT   (32'd10),
    .DBL_GAP      (32'd0),
    .REPEAT_COUNT (32'd4),
    .CNT_W        (32'd20)
  ) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn0_n),
    .evt_press   (z_press),
    .evt_release (z_release),
    .evt_short   (z_short),
    .evt_double  (z_double),
    .evt_long    (z_long),
    .evt_repeat  (z_repeat),
    .pressed     (z_pressed),
    .busy        (z_busy)
  );

  assign m_vec = {m_press, m_release, m_short, m_double, m_long, m_repeat, m_pressed, m_busy};
  assign z_vec = {z_press, z_release, z_short, z_double, z_long, z_repeat, z_pressed, z_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %b expected %b", tag, row, got, exp);
    end
  endtask

  // n rows with one DUT's button at level b (the other held released)
  task automatic run(input string tag, input bit sel, input int n,
                     input logic b, input logic [7:0] e);
    for (int i = 0; i < n; i++) begin
      if (sel) begin
        btn0_n = b;
        btn_n  = 1'b1;
      end else begin
        btn_n  = b;
        btn0_n = 1'b1;
      end
      @(negedge clk);
      row++;
      chk(tag, sel ? z_vec : m_vec, e);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    row    = 0;
    rst_n  = 1'b0;
    btn_n  = 1'b0;
    btn0_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset", m_vec, V_Z);
    chk("reset0", z_vec, V_Z);

    // Button held across reset release: nothing happens
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      row++;
      chk("held", m_vec, V_Z);
      chk("held0", z_vec, V_Z);
    end
    btn_n  = 1'b1;
    btn0_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      row++;
      chk("arm", m_vec, V_Z);
      chk("arm0", z_vec, V_Z);
    end

    // Single 3-cycle click: short comes 6 cycles after release
    run("click", 1'b0, 1, 1'b0, V_P);
    run("click", 1'b0, 2, 1'b0, V_H);
    run("click", 1'b0, 1, 1'b1, V_RG);
    run("click", 1'b0, 5, 1'b1, V_G);
    run("click", 1'b0, 1, 1'b1, V_S);
    run("click", 1'b0, 3, 1'b1, V_Z);

    // Double click: two 3-cycle lows, 2 high cycles between
    run("dbl", 1'b0, 1, 1'b0, V_P);
    run("dbl", 1'b0, 2, 1'b0, V_H);
    run("dbl", 1'b0, 1, 1'b1, V_RG);
    run("dbl", 1'b0, 1, 1'b1, V_G);
    run("dbl", 1'b0, 1, 1'b0, V_P);
    run("dbl", 1'b0, 2, 1'b0, V_H);
    run("dbl", 1'b0, 1, 1'b1, V_D);
    run("dbl", 1'b0, 8, 1'b1, V_Z);

    // Long hold of 20 cycles: long at +10, repeats at +4 and +8 after it
    run("long", 1'b0, 1, 1'b0, V_P);
    run("long", 1'b0, 9, 1'b0, V_H);
    run("long", 1'b0, 1, 1'b0, V_L);
    run("long", 1'b0, 3, 1'b0, V_H);
    run("long", 1'b0, 1, 1'b0, V_RP);
    run("long", 1'b0, 3, 1'b0, V_H);
    run("long", 1'b0, 1, 1'b0, V_RP);
    run("long", 1'b0, 1, 1'b0, V_H);
    run("long", 1'b0, 1, 1'b1, V_RL);
    run("long", 1'b0, 8, 1'b1, V_Z);

    // Second press sampled on the gap-timeout edge: press wins, no short
    run("edge", 1'b0, 1, 1'b0, V_P);
    run("edge", 1'b0, 2, 1'b0, V_H);
    run("edge", 1'b0, 1, 1'b1, V_RG);
    run("edge", 1'b0, 5, 1'b1, V_G);
    run("edge", 1'b0, 1, 1'b0, V_P);
    run("edge", 1'b0, 2, 1'b0, V_H);
    run("edge", 1'b0, 1, 1'b1, V_D);
    run("edge", 1'b0, 8, 1'b1, V_Z);

    // Double-click disabled: release and short together, busy already low
    run("nogap", 1'b1, 1, 1'b0, V_P);
    run("nogap", 1'b1, 2, 1'b0, V_H);
    run("nogap", 1'b1, 1, 1'b1, V_RS);
    run("nogap", 1'b1, 3, 1'b1, V_Z);

    // Reset mid-hold: outputs clear at once, no long, re-arm needed
    run("rsthold", 1'b0, 1, 1'b0, V_P);
    run("rsthold", 1'b0, 4, 1'b0, V_H);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", m_vec, V_Z);
    chk("rst_async0", z_vec, V_Z);
    @(negedge clk);
    chk("rst_hold", m_vec, V_Z);
    rst_n = 1'b1;
    run("rearm", 1'b0, 12, 1'b0, V_Z);
    run("rearm", 1'b0, 2, 1'b1, V_Z);
    run("rearm", 1'b0, 1, 1'b0, V_P);
    run("rearm", 1'b0, 2, 1'b0, V_H);
    run("rearm", 1'b0, 1, 1'b1, V_RG);
    run("rearm", 1'b0, 5, 1'b1, V_G);
    run("rearm", 1'b0, 1, 1'b1, V_S);
    run("rearm", 1'b0, 2, 1'b1, V_Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
